// File: rtl/hazard_scoreboard_pkg.sv
// Shared defaults and the per-register counter width helper for the hazard scoreboard.
// The counter must be wide enough to hold the larger of the two stall distances.
package hazard_pkg;

  localparam int DEF_REG_ADDR_W     = 5;
  localparam int DEF_LOAD_USE_STALL = 1;
  localparam int DEF_WB_DIST        = 2;
  localparam int DEF_STALL_CNT_W    = 32;

  // A width of at least 1 keeps degenerate parameter choices elaborating.
  function automatic int cnt_width(input int load_use_stall, input int wb_dist);
    int max_v;
    int w;
    max_v = (load_use_stall > wb_dist) ? load_use_stall : wb_dist;
    w     = $clog2(max_v + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Issue-stage bundle between the decode stage (master) and the hazard scoreboard (slave).
interface hazard_scoreboard_if
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
  parameter int STALL_CNT_W = DEF_STALL_CNT_W
);

  logic                   issue_valid;
  logic [REG_ADDR_W-1:0]  src1;
  logic [REG_ADDR_W-1:0]  src2;
  logic                   single_src;
  logic [REG_ADDR_W-1:0]  dest;
  logic                   wb_en;
  logic                   is_load;
  logic                   forwarding_enable;
  logic                   flush;
  logic                   hazard_detected;
  logic                   pending_any;
  logic [STALL_CNT_W-1:0] stall_cycles;

  modport master (
    output issue_valid, src1, src2, single_src, dest, wb_en, is_load,
           forwarding_enable, flush,
    input  hazard_detected, pending_any, stall_cycles
  );

  modport slave (
    input  issue_valid, src1, src2, single_src, dest, wb_en, is_load,
           forwarding_enable, flush,
    output hazard_detected, pending_any, stall_cycles
  );

endinterface

// File: rtl/hazard_scoreboard_reg_counter.sv
// Remaining-stall counter for one architectural register: load, free-running decrement, clear.
module hazard_reg_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load_en,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] dec_val;

  always_comb begin
    dec_val = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
    cnt_d   = dec_val;
    // A reload never shortens an older, longer pending wait on the same register.
    if (load_en && (load_val > dec_val)) begin
      cnt_d = load_val;
    end
    if (clear) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Register-dependency scoreboard: stalls ID while a source register still has pending
// cycles before its producer's result is usable, and counts stalled cycles.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W     = DEF_REG_ADDR_W,
  parameter int LOAD_USE_STALL = DEF_LOAD_USE_STALL,
  parameter int WB_DIST        = DEF_WB_DIST,
  parameter int STALL_CNT_W    = DEF_STALL_CNT_W
) (
  input  logic          clk,
  input  logic          rst,
  hazard_scoreboard_if.slave bus
);

  localparam int NUM_REGS = 2 ** REG_ADDR_W;
  localparam int CNT_W    = cnt_width(LOAD_USE_STALL, WB_DIST);

  logic [CNT_W-1:0]       cnt [NUM_REGS];
  logic [NUM_REGS-1:1]    load_sel;
  logic [NUM_REGS-1:1]    cnt_nz;
  logic [CNT_W-1:0]       load_val;
  logic                   hazard;
  logic                   issue;
  logic                   load_any;
  logic [STALL_CNT_W-1:0] stall_q;
  logic [STALL_CNT_W-1:0] stall_d;

  // Register 0 is hardwired, so it can never be a dependency.
  assign cnt[0] = '0;

  always_comb begin
    hazard = 1'b0;
    if (bus.issue_valid) begin
      hazard = (cnt[bus.src1] != '0) ||
               (!bus.single_src && (cnt[bus.src2] != '0));
    end
  end

  assign issue    = bus.issue_valid && !hazard && !bus.flush;
  assign load_any = issue && bus.wb_en && (bus.dest != '0);

  always_comb begin
    load_val = '0;
    if (!bus.forwarding_enable) begin
      load_val = CNT_W'(WB_DIST);
    end else if (bus.is_load) begin
      load_val = CNT_W'(LOAD_USE_STALL);
    end
  end

  generate
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
      assign load_sel[gi] = load_any && (bus.dest == REG_ADDR_W'(gi));
      assign cnt_nz[gi]   = (cnt[gi] != '0);

      hazard_reg_counter #(
        .CNT_W (CNT_W)
      ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear    (bus.flush),
        .load_en  (load_sel[gi]),
        .load_val (load_val),
        .cnt      (cnt[gi])
      );
    end
  endgenerate

  always_comb begin
    stall_d = stall_q;
    if (hazard && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign bus.hazard_detected = hazard;
  assign bus.pending_any     = |cnt_nz;
  assign bus.stall_cycles    = stall_q;

endmodule
